wr_request_burst: RTL and testbench
===================================

# wr_request_burst

Parametrised burst-capable successor to the frame write-request master in the ASCON accelerator's write path. It drains per-frame CKN/AD, text and tag FIFOs into an Avalon-MM burst write master, writing up to MAX_BURST words per request. Hash codes go to a separate output region. On tag failure it rolls back the frame's CKN/AD writes. It sits between the store/result FIFOs and the system interconnect and signals completion to the done/IRQ logic.

## Interface
- DATA_W, 32: data word width, multiple of 8; BYTES = DATA_W/8.
- ADDR_W, 32: byte address width.
- MAX_BURST, 8: maximum beats per burst, power of two, ≥1.
- BC_W, $clog2(MAX_BURST)+1: burstcount width.
- LVL_W, 9: FIFO level input width.
- TAG_WORDS, 4: tag length in words, ≥1.
- CNT_W, 16: frame/fail counter width.
- iClk in 1: clock, all logic rising-edge.
- iRstn in 1: asynchronous active-low reset.
- oAddress_Master_Write out ADDR_W: burst start address.
- oData_Master_Write out DATA_W: write beat data.
- oWrite_Master_Write out 1: write request.
- oBurstcount_Master_Write out BC_W: beats in the current burst.
- iWait_Master_Write in 1: waitrequest.
- start_i in 1: job start pulse.
- d_addr_i in ADDR_W: AEAD destination base.
- out_gap_i in ADDR_W: hash region offset from d_addr_i.
- frames_i in CNT_W: frames in the job; 0 is treated as 1.
- info_avail_i in 1 / info_req_o out 1 / info_i in 18: per-frame info. Bit 17 = dec, bit 16 = hash, [15:8] = CKN/AD words, [7:0] = text words.
- res_avail_i in 1 / res_fetch_o out 1 / res_data_i in 1: result, 1 = pass, 0 = tag fail.
- {ckn,text,tag}_data_i in DATA_W: show-ahead FIFO head.
- {ckn,text,tag}_level_i in LVL_W: FIFO occupancy.
- {ckn,text,tag}_fetch_o out 1: pop, one per accepted beat.
- tag_fail_nums_o out CNT_W: failed frames in the current job.
- end_addr_write_o out ADDR_W: final AEAD pointer.
- done_o out 1: job complete pulse.
- busy_o out 1: high when not IDLE.

## Operation
- States: IDLE, INFO, SEG_WAIT, BURST, RES, FRAME_END.
- IDLE, on start_i:
  - aead_ptr ← d_addr_i; hash_ptr ← d_addr_i + out_gap_i.
  - frame_cnt ← 0; tag_fail_nums_o ← 0.
  - Go to INFO. start_i outside IDLE is ignored.
- INFO, on info_avail_i:
  - info_req_o pulses for one cycle; fields are latched.
  - Segment ← CKN with rem = CKN words.
  - Go to SEG_WAIT. A zero-length segment is skipped via the next-segment rule.
- SEG_WAIT:
  - blen = min(rem, MAX_BURST).
  - Enter BURST once the selected FIFO's level ≥ blen.
  - Burst address is hash_ptr for the text segment when hash=1; otherwise aead_ptr.
- BURST:
  - oWrite, oAddress and oBurstcount are held constant for the whole burst.
  - Each beat presents the selected FIFO head on oData.
  - A beat is accepted when oWrite & ~iWait. That cycle pulses the matching fetch_o and decrements rem.
  - After the last beat, the pointer used advances by blen*BYTES (mod 2^ADDR_W).
  - Then: SEG_WAIT if rem > 0, otherwise the next-segment rule.
- Next-segment rule:
  - After CKN → RES.
  - After TEXT → FRAME_END if dec|hash; otherwise TAG with rem = TAG_WORDS.
  - After TAG → FRAME_END.
- RES, on res_avail_i:
  - res_fetch_o pulses.
  - res_data_i = 1: go to TEXT.
  - res_data_i = 0: aead_ptr −= CKN words*BYTES, tag_fail_nums_o += 1, go to FRAME_END. Upstream pushes no text or tag for a failed frame.
- FRAME_END:
  - If frame_cnt == max(frames_i,1) − 1: done_o pulses, end_addr_write_o ← aead_ptr, go to IDLE.
  - Otherwise frame_cnt += 1 and go to INFO.
- Counters wrap modulo 2^CNT_W.

## Timing
- Reset values: all outputs 0, state IDLE, all pointers and counters 0.
- Reset mid-burst drops the burst immediately with no completion.
- oAddress, oData and oBurstcount are 0 whenever oWrite = 0.
- fetch_o is combinational, asserted in the same cycle the beat is accepted. It never asserts while iWait is high.
- Minimum latency: start_i → first oWrite is 3 cycles (IDLE→INFO→SEG_WAIT→BURST), with info and data available.
- A burst of N beats with no wait takes N cycles. One SEG_WAIT cycle separates consecutive bursts.
- info_req_o and res_fetch_o are single-cycle pulses, issued only when the corresponding avail signal is high.
- done_o and the end_addr_write_o update occur in the same cycle.

## Test plan
- Encrypt frame, MAX_BURST=4, DATA_W=32, d_addr=0x1000, CKN 6, text 5, pass:
  - Bursts 4@0x1000, 2@0x1010, 4@0x1018, 1@0x1028, 4@0x102C.
  - done_o pulses once; end_addr_write_o = 0x103C.
- Tag fail: frame 1 has CKN 6 with res = 0; frame 2 passes.
  - Frame 2 CKN burst starts at 0x1000; tag_fail_nums_o = 1.
  - No text or tag fetches occur for frame 1.
- Hash, out_gap = 0x100, two frames of CKN 2, text 3:
  - Text bursts start at 0x1100 then 0x110C; CKN bursts start at 0x1000 then 0x1008.
  - No tag writes; end_addr_write_o = 0x1010.
- Backpressure: iWait held for 3 cycles on beat 2 of a 4-beat burst.
  - Address, burstcount and data stay stable throughout.
  - Exactly 4 fetch pulses occur, none during wait.
- Starvation: ckn_level_i = 3 with blen = 4.
  - No oWrite until level reaches 4; then one 4-beat burst.
- Reset asserted mid-burst:
  - All outputs are 0 in the same cycle.
  - A subsequent start_i with d_addr = 0x2000 begins cleanly at 0x2000.

Source files
------------

// File: rtl/wr_request_burst.sv
`default_nettype none
// ============================================================================
// Module   : wr_request_burst
// Brief    : Avalon-MM burst write master draining per-frame CKN/AD, text and
//            tag FIFOs, with hash redirection and CKN/AD rollback on tag fail.
// Revision : 1.0
// ============================================================================
module wr_request_burst #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 8,
    parameter int BC_W      = $clog2(MAX_BURST) + 1,
    parameter int LVL_W     = 9,
    parameter int TAG_WORDS = 4,
    parameter int CNT_W     = 16
) (
    input  logic              iClk,
    input  logic              iRstn,
    output logic [ADDR_W-1:0] oAddress_Master_Write,
    output logic [DATA_W-1:0] oData_Master_Write,
    output logic              oWrite_Master_Write,
    output logic [BC_W-1:0]   oBurstcount_Master_Write,
    input  logic              iWait_Master_Write,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [ADDR_W-1:0] out_gap_i,
    input  logic [CNT_W-1:0]  frames_i,
    input  logic              info_avail_i,
    output logic              info_req_o,
    input  logic [17:0]       info_i,
    input  logic              res_avail_i,
    output logic              res_fetch_o,
    input  logic              res_data_i,
    input  logic [DATA_W-1:0] ckn_data_i,
    input  logic [DATA_W-1:0] text_data_i,
    input  logic [DATA_W-1:0] tag_data_i,
    input  logic [LVL_W-1:0]  ckn_level_i,
    input  logic [LVL_W-1:0]  text_level_i,
    input  logic [LVL_W-1:0]  tag_level_i,
    output logic              ckn_fetch_o,
    output logic              text_fetch_o,
    output logic              tag_fetch_o,
    output logic [CNT_W-1:0]  tag_fail_nums_o,
    output logic [ADDR_W-1:0] end_addr_write_o,
    output logic              done_o,
    output logic              busy_o
);

    localparam int REM_W = 16;

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_INFO      = 3'd1;
    localparam logic [2:0] c_SEG_WAIT  = 3'd2;
    localparam logic [2:0] c_BURST     = 3'd3;
    localparam logic [2:0] c_RES       = 3'd4;
    localparam logic [2:0] c_FRAME_END = 3'd5;

    localparam logic [1:0] c_SEG_CKN  = 2'd0;
    localparam logic [1:0] c_SEG_TEXT = 2'd1;
    localparam logic [1:0] c_SEG_TAG  = 2'd2;

    localparam logic [REM_W-1:0]  c_MAX_REM = REM_W'(MAX_BURST);
    localparam logic [BC_W-1:0]   c_MAX_BC  = BC_W'(MAX_BURST);
    localparam logic [REM_W-1:0]  c_TAG_REM = REM_W'(TAG_WORDS);
    localparam logic [ADDR_W-1:0] c_BYTES   = ADDR_W'(DATA_W / 8);

    logic [2:0]        r_state;
    logic [1:0]        r_seg;
    logic [REM_W-1:0]  r_rem;
    logic [BC_W-1:0]   r_beats;
    logic [BC_W-1:0]   r_blen;
    logic [ADDR_W-1:0] r_burst_addr;
    logic              r_use_hash;
    logic              r_dec;
    logic              r_hash;
    logic [7:0]        r_ckn_words;
    logic [7:0]        r_text_words;
    logic [ADDR_W-1:0] r_aead_ptr;
    logic [ADDR_W-1:0] r_hash_ptr;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic [CNT_W-1:0]  r_tag_fail;
    logic [ADDR_W-1:0] r_end_addr;
    logic              r_done;

    logic              w_in_burst;
    logic              w_accept;
    logic [DATA_W-1:0] w_head;
    logic [LVL_W-1:0]  w_level;
    logic [BC_W-1:0]   w_blen;
    logic              w_level_ok;
    logic              w_use_hash;
    logic [ADDR_W-1:0] w_adv;
    logic [CNT_W-1:0]  w_frames_m1;
    logic              w_last_frame;
    logic [2:0]        w_ns_state;
    logic [1:0]        w_ns_seg;
    logic [REM_W-1:0]  w_ns_rem;

    assign w_in_burst   = (r_state == c_BURST);
    assign w_accept     = w_in_burst & ~iWait_Master_Write;
    assign w_blen       = (r_rem < c_MAX_REM) ? r_rem[BC_W-1:0] : c_MAX_BC;
    assign w_level_ok   = (32'(w_level) >= 32'(w_blen));
    assign w_use_hash   = (r_seg == c_SEG_TEXT) & r_hash;
    assign w_adv        = ADDR_W'(r_blen) * c_BYTES;
    assign w_frames_m1  = (frames_i == '0) ? '0 : frames_i - CNT_W'(1);
    assign w_last_frame = (r_frame_cnt == w_frames_m1);

    always_comb begin
        w_head  = '0;
        w_level = '0;
        case (r_seg)
            c_SEG_CKN:  begin w_head = ckn_data_i;  w_level = ckn_level_i;  end
            c_SEG_TEXT: begin w_head = text_data_i; w_level = text_level_i; end
            c_SEG_TAG:  begin w_head = tag_data_i;  w_level = tag_level_i;  end
            default:    begin w_head = '0;          w_level = '0;           end
        endcase
    end

    // Where a finished (or empty) segment hands over to
    always_comb begin
        w_ns_state = c_FRAME_END;
        w_ns_seg   = r_seg;
        w_ns_rem   = '0;
        case (r_seg)
            c_SEG_CKN:  w_ns_state = c_RES;
            c_SEG_TEXT: begin
                if (!(r_dec | r_hash)) begin
                    w_ns_state = c_SEG_WAIT;
                    w_ns_seg   = c_SEG_TAG;
                    w_ns_rem   = c_TAG_REM;
                end
            end
            default:    w_ns_state = c_FRAME_END;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            r_state      <= c_IDLE;
            r_seg        <= c_SEG_CKN;
            r_rem        <= '0;
            r_beats      <= '0;
            r_blen       <= '0;
            r_burst_addr <= '0;
            r_use_hash   <= 1'b0;
            r_dec        <= 1'b0;
            r_hash       <= 1'b0;
            r_ckn_words  <= '0;
            r_text_words <= '0;
            r_aead_ptr   <= '0;
            r_hash_ptr   <= '0;
            r_frame_cnt  <= '0;
            r_tag_fail   <= '0;
            r_end_addr   <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start_i) begin
                        r_aead_ptr  <= d_addr_i;
                        r_hash_ptr  <= d_addr_i + out_gap_i;
                        r_frame_cnt <= '0;
                        r_tag_fail  <= '0;
                        r_state     <= c_INFO;
                    end
                end
                c_INFO: begin
                    if (info_avail_i) begin
                        r_dec        <= info_i[17];
                        r_hash       <= info_i[16];
                        r_ckn_words  <= info_i[15:8];
                        r_text_words <= info_i[7:0];
                        r_seg        <= c_SEG_CKN;
                        r_rem        <= REM_W'(info_i[15:8]);
                        r_state      <= c_SEG_WAIT;
                    end
                end
                c_SEG_WAIT: begin
                    if (r_rem == '0) begin
                        r_state <= w_ns_state;
                        r_seg   <= w_ns_seg;
                        r_rem   <= w_ns_rem;
                    end else if (w_level_ok) begin
                        r_blen       <= w_blen;
                        r_beats      <= w_blen;
                        r_use_hash   <= w_use_hash;
                        r_burst_addr <= w_use_hash ? r_hash_ptr : r_aead_ptr;
                        r_state      <= c_BURST;
                    end
                end
                c_BURST: begin
                    if (w_accept) begin
                        r_rem   <= r_rem - REM_W'(1);
                        r_beats <= r_beats - BC_W'(1);
                        if (r_beats == BC_W'(1)) begin
                            if (r_use_hash) r_hash_ptr <= r_hash_ptr + w_adv;
                            else            r_aead_ptr <= r_aead_ptr + w_adv;
                            if (r_rem != REM_W'(1)) begin
                                r_state <= c_SEG_WAIT;
                            end else begin
                                r_state <= w_ns_state;
                                r_seg   <= w_ns_seg;
                                r_rem   <= w_ns_rem;
                            end
                        end
                    end
                end
                c_RES: begin
                    if (res_avail_i) begin
                        if (res_data_i) begin
                            r_seg   <= c_SEG_TEXT;
                            r_rem   <= REM_W'(r_text_words);
                            r_state <= c_SEG_WAIT;
                        end else begin
                            // Rewind so the next frame overwrites the rejected CKN/AD
                            r_aead_ptr <= r_aead_ptr - ADDR_W'(r_ckn_words) * c_BYTES;
                            r_tag_fail <= r_tag_fail + CNT_W'(1);
                            r_state    <= c_FRAME_END;
                        end
                    end
                end
                c_FRAME_END: begin
                    if (w_last_frame) begin
                        r_done     <= 1'b1;
                        r_end_addr <= r_aead_ptr;
                        r_state    <= c_IDLE;
                    end else begin
                        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                        r_state     <= c_INFO;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign oWrite_Master_Write      = w_in_burst;
    assign oAddress_Master_Write    = w_in_burst ? r_burst_addr : '0;
    assign oBurstcount_Master_Write = w_in_burst ? r_blen : '0;
    assign oData_Master_Write       = w_in_burst ? w_head : '0;

    assign ckn_fetch_o  = w_accept & (r_seg == c_SEG_CKN);
    assign text_fetch_o = w_accept & (r_seg == c_SEG_TEXT);
    assign tag_fetch_o  = w_accept & (r_seg == c_SEG_TAG);

    assign info_req_o  = (r_state == c_INFO) & info_avail_i;
    assign res_fetch_o = (r_state == c_RES) & res_avail_i;

    assign tag_fail_nums_o  = r_tag_fail;
    assign end_addr_write_o = r_end_addr;
    assign done_o           = r_done;
    assign busy_o           = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_wr_request_burst.sv
`default_nettype none
// Directed bench for wr_request_burst: info/result servers, FIFO heads as
// counters, and a burst log compared against hand-computed addresses.
module tb_wr_request_burst;
    localparam int DATA_W = 32, ADDR_W = 32, MAX_BURST = 4, BC_W = 3;
    localparam int LVL_W = 9, TAG_WORDS = 4, CNT_W = 16;

    logic iClk = 1'b0;
    logic iRstn = 1'b0;
    always #5 iClk = ~iClk;

    logic [ADDR_W-1:0] oAddress_Master_Write;
    logic [DATA_W-1:0] oData_Master_Write;
    logic              oWrite_Master_Write;
    logic [BC_W-1:0]   oBurstcount_Master_Write;
    logic              iWait_Master_Write = 1'b0;
    logic              start_i = 1'b0;
    logic [ADDR_W-1:0] d_addr_i = '0;
    logic [ADDR_W-1:0] out_gap_i = '0;
    logic [CNT_W-1:0]  frames_i = '0;
    logic              info_avail_i, info_req_o, res_avail_i, res_fetch_o, res_data_i;
    logic [17:0]       info_i;
    logic [DATA_W-1:0] ckn_data_i, text_data_i, tag_data_i;
    logic [LVL_W-1:0]  ckn_level_i = 9'd100, text_level_i = 9'd100, tag_level_i = 9'd100;
    logic              ckn_fetch_o, text_fetch_o, tag_fetch_o, done_o, busy_o;
    logic [CNT_W-1:0]  tag_fail_nums_o;
    logic [ADDR_W-1:0] end_addr_write_o;

    wr_request_burst #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST), .BC_W(BC_W),
        .LVL_W(LVL_W), .TAG_WORDS(TAG_WORDS), .CNT_W(CNT_W)
    ) dut (
        .iClk(iClk), .iRstn(iRstn),
        .oAddress_Master_Write(oAddress_Master_Write),
        .oData_Master_Write(oData_Master_Write),
        .oWrite_Master_Write(oWrite_Master_Write),
        .oBurstcount_Master_Write(oBurstcount_Master_Write),
        .iWait_Master_Write(iWait_Master_Write),
        .start_i(start_i), .d_addr_i(d_addr_i), .out_gap_i(out_gap_i), .frames_i(frames_i),
        .info_avail_i(info_avail_i), .info_req_o(info_req_o), .info_i(info_i),
        .res_avail_i(res_avail_i), .res_fetch_o(res_fetch_o), .res_data_i(res_data_i),
        .ckn_data_i(ckn_data_i), .text_data_i(text_data_i), .tag_data_i(tag_data_i),
        .ckn_level_i(ckn_level_i), .text_level_i(text_level_i), .tag_level_i(tag_level_i),
        .ckn_fetch_o(ckn_fetch_o), .text_fetch_o(text_fetch_o), .tag_fetch_o(tag_fetch_o),
        .tag_fail_nums_o(tag_fail_nums_o), .end_addr_write_o(end_addr_write_o),
        .done_o(done_o), .busy_o(busy_o)
    );

    int checks = 0;
    int failures = 0;

    // Upstream models
    int ckn_idx = 0, text_idx = 0, tag_idx = 0;
    logic [17:0] info_mem [16];
    logic        res_mem  [16];
    int info_wr = 0, info_rd = 0, res_wr = 0, res_rd = 0;
    assign ckn_data_i   = 32'hC000_0000 + 32'(ckn_idx);
    assign text_data_i  = 32'hD000_0000 + 32'(text_idx);
    assign tag_data_i   = 32'hE000_0000 + 32'(tag_idx);
    assign info_avail_i = (info_rd != info_wr);
    assign info_i       = info_mem[info_rd[3:0]];
    assign res_avail_i  = (res_rd != res_wr);
    assign res_data_i   = res_mem[res_rd[3:0]];

    // Monitor state
    int cyc = 0, nb = 0, first_wr_cyc = -1, wr_cyc = 0, wait_cyc = 0;
    int n_ckn = 0, n_text = 0, n_tag = 0, n_done = 0;
    int data_err = 0, zero_err = 0, stab_err = 0, wait_fetch_err = 0;
    logic [ADDR_W-1:0] log_addr [32];
    logic [BC_W-1:0]   log_bc   [32];
    logic [ADDR_W-1:0] hold_addr = '0, last_end = '0;
    logic [BC_W-1:0]   hold_bc = '0;
    logic [DATA_W-1:0] prev_data = '0;
    logic prev_wr = 1'b0, prev_wait = 1'b0;
    bit pend_ckn = 0, pend_text = 0, pend_tag = 0, pend_info = 0, pend_res = 0;

    always @(posedge iClk) cyc++;

    always @(negedge iClk) begin
        if (oWrite_Master_Write) begin
            wr_cyc++;
            if (!prev_wr) begin
                if (nb < 32) begin
                    log_addr[nb] = oAddress_Master_Write;
                    log_bc[nb]   = oBurstcount_Master_Write;
                end
                nb++;
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                hold_addr = oAddress_Master_Write;
                hold_bc   = oBurstcount_Master_Write;
            end else if (oAddress_Master_Write !== hold_addr || oBurstcount_Master_Write !== hold_bc) begin
                stab_err++;
            end
            if (prev_wr && prev_wait && oData_Master_Write !== prev_data) stab_err++;
            if (iWait_Master_Write) wait_cyc++;
        end else if (oAddress_Master_Write !== '0 || oData_Master_Write !== '0 || oBurstcount_Master_Write !== '0) begin
            zero_err++;
        end
        if (iWait_Master_Write && (ckn_fetch_o || text_fetch_o || tag_fetch_o)) wait_fetch_err++;
        if (ckn_fetch_o) begin
            if (oData_Master_Write !== 32'hC000_0000 + 32'(ckn_idx)) data_err++;
            n_ckn++; pend_ckn = 1;
        end
        if (text_fetch_o) begin
            if (oData_Master_Write !== 32'hD000_0000 + 32'(text_idx)) data_err++;
            n_text++; pend_text = 1;
        end
        if (tag_fetch_o) begin
            if (oData_Master_Write !== 32'hE000_0000 + 32'(tag_idx)) data_err++;
            n_tag++; pend_tag = 1;
        end
        if (info_req_o) pend_info = 1;
        if (res_fetch_o) pend_res = 1;
        if (done_o) begin n_done++; last_end = end_addr_write_o; end
        prev_wr = oWrite_Master_Write; prev_wait = iWait_Master_Write; prev_data = oData_Master_Write;
    end

    // Pops land just after the edge so the DUT samples the old heads
    always @(posedge iClk) begin
        #1;
        if (pend_ckn)  ckn_idx++;
        if (pend_text) text_idx++;
        if (pend_tag)  tag_idx++;
        if (pend_info) info_rd++;
        if (pend_res)  res_rd++;
        pend_ckn = 0; pend_text = 0; pend_tag = 0; pend_info = 0; pend_res = 0;
    end

    task automatic clear_log();
        nb = 0; first_wr_cyc = -1; wr_cyc = 0; wait_cyc = 0;
        n_ckn = 0; n_text = 0; n_tag = 0; n_done = 0;
        data_err = 0; zero_err = 0; stab_err = 0; wait_fetch_err = 0;
        last_end = '0;
    endtask

    task automatic do_reset();
        iRstn = 1'b0;
        repeat (2) @(posedge iClk);
        #2;
        info_rd = info_wr; res_rd = res_wr;
        clear_log();
        iRstn = 1'b1;
    endtask

    task automatic push_frame(input bit dec, input bit hash, input int ckn, input int txt, input bit res);
        info_mem[info_wr[3:0]] = {dec, hash, 8'(ckn), 8'(txt)};
        info_wr++;
        res_mem[res_wr[3:0]] = res;
        res_wr++;
    endtask

    task automatic start_job(input logic [31:0] addr, input logic [31:0] gap, input int frames, output int start_cyc);
        @(posedge iClk); #1;
        clear_log();
        d_addr_i = addr; out_gap_i = gap; frames_i = 16'(frames);
        start_i = 1'b1; start_cyc = cyc;
        @(posedge iClk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        while (n_done == 0 && n < budget) begin @(posedge iClk); n++; end
        #2;
        ok = (n_done != 0);
    endtask

    task automatic test_reset();
        do_reset();
        @(posedge iClk); #1;
        checks++; if (oWrite_Master_Write !== 1'b0) begin failures++; $display("FAIL reset_write: got %b want 0", oWrite_Master_Write); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (done_o !== 1'b0 || tag_fail_nums_o !== '0 || end_addr_write_o !== '0) begin
            failures++; $display("FAIL reset_status: got done=%b fail=%0d end=%h want 0/0/0", done_o, tag_fail_nums_o, end_addr_write_o); end
        checks++; if ({oAddress_Master_Write, oData_Master_Write, oBurstcount_Master_Write} !== '0) begin
            failures++; $display("FAIL reset_bus: got addr=%h data=%h bc=%0d want 0", oAddress_Master_Write, oData_Master_Write, oBurstcount_Master_Write); end
    endtask

    task automatic test_encrypt();
        logic [31:0] ea [5] = '{32'h1000, 32'h1010, 32'h1018, 32'h1028, 32'h102C};
        int          eb [5] = '{4, 2, 4, 1, 4};
        int s; bit ok;
        push_frame(0, 0, 6, 5, 1);
        start_job(32'h1000, 32'h0, 1, s);
        wait_done(200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL enc_done: timeout, done not seen"); end
        checks++; if (first_wr_cyc - s != 3) begin failures++; $display("FAIL enc_latency: got %0d want 3", first_wr_cyc - s); end
        checks++; if (nb != 5) begin failures++; $display("FAIL enc_nbursts: got %0d want 5", nb); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (log_addr[i] !== ea[i] || 32'(log_bc[i]) != eb[i]) begin
                failures++; $display("FAIL enc_burst%0d: got %0d@%h want %0d@%h", i, log_bc[i], log_addr[i], eb[i], ea[i]); end
        end
        checks++; if (last_end !== 32'h103C || n_done != 1) begin failures++; $display("FAIL enc_end: got %h x%0d want 103c x1", last_end, n_done); end
        checks++; if (n_ckn != 6 || n_text != 5 || n_tag != 4) begin
            failures++; $display("FAIL enc_fetches: got %0d/%0d/%0d want 6/5/4", n_ckn, n_text, n_tag); end
        checks++; if (data_err != 0 || zero_err != 0 || stab_err != 0) begin
            failures++; $display("FAIL enc_bus: got data_err=%0d zero_err=%0d stab_err=%0d want 0", data_err, zero_err, stab_err); end
    endtask

    task automatic test_tag_fail();
        logic [31:0] ea [7] = '{32'h1000, 32'h1010, 32'h1000, 32'h1010, 32'h1018, 32'h1028, 32'h102C};
        int          eb [7] = '{4, 2, 4, 2, 4, 1, 4};
        int s; bit ok;
        push_frame(0, 0, 6, 5, 0);
        push_frame(0, 0, 6, 5, 1);
        start_job(32'h1000, 32'h0, 2, s);
        wait_done(300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL fail_done: timeout, done not seen"); end
        checks++; if (nb != 7) begin failures++; $display("FAIL fail_nbursts: got %0d want 7", nb); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (log_addr[i] !== ea[i] || 32'(log_bc[i]) != eb[i]) begin
                failures++; $display("FAIL fail_burst%0d: got %0d@%h want %0d@%h", i, log_bc[i], log_addr[i], eb[i], ea[i]); end
        end
        checks++; if (tag_fail_nums_o !== 16'd1) begin failures++; $display("FAIL fail_count: got %0d want 1", tag_fail_nums_o); end
        checks++; if (n_text != 5 || n_tag != 4) begin failures++; $display("FAIL fail_fetches: got text=%0d tag=%0d want 5/4", n_text, n_tag); end
        checks++; if (last_end !== 32'h103C) begin failures++; $display("FAIL fail_end: got %h want 103c", last_end); end
    endtask

    task automatic test_hash();
        logic [31:0] ea [4] = '{32'h1000, 32'h1100, 32'h1008, 32'h110C};
        int          eb [4] = '{2, 3, 2, 3};
        int s; bit ok;
        push_frame(0, 1, 2, 3, 1);
        push_frame(0, 1, 2, 3, 1);
        start_job(32'h1000, 32'h100, 2, s);
        wait_done(200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL hash_done: timeout, done not seen"); end
        checks++; if (nb != 4) begin failures++; $display("FAIL hash_nbursts: got %0d want 4", nb); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_addr[i] !== ea[i] || 32'(log_bc[i]) != eb[i]) begin
                failures++; $display("FAIL hash_burst%0d: got %0d@%h want %0d@%h", i, log_bc[i], log_addr[i], eb[i], ea[i]); end
        end
        checks++; if (n_tag != 0) begin failures++; $display("FAIL hash_tag: got %0d tag fetches want 0", n_tag); end
        checks++; if (last_end !== 32'h1010) begin failures++; $display("FAIL hash_end: got %h want 1010", last_end); end
    endtask

    task automatic test_backpressure();
        int s, n; bit ok;
        push_frame(1, 0, 4, 0, 1);
        start_job(32'h1000, 32'h0, 1, s);
        n = 0;
        while (!oWrite_Master_Write && n < 20) begin @(posedge iClk); #1; n++; end
        checks++; if (!oWrite_Master_Write) begin failures++; $display("FAIL bp_start: timeout, oWrite not seen"); end
        @(posedge iClk); #1;
        iWait_Master_Write = 1'b1;
        repeat (3) @(posedge iClk);
        #1;
        iWait_Master_Write = 1'b0;
        wait_done(100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_done: timeout, done not seen"); end
        checks++; if (n_ckn != 4) begin failures++; $display("FAIL bp_fetches: got %0d want 4", n_ckn); end
        checks++; if (wait_fetch_err != 0) begin failures++; $display("FAIL bp_fetch_in_wait: got %0d want 0", wait_fetch_err); end
        checks++; if (stab_err != 0) begin failures++; $display("FAIL bp_stable: got %0d changes want 0", stab_err); end
        checks++; if (wait_cyc != 3 || wr_cyc != 7) begin failures++; $display("FAIL bp_cycles: got wait=%0d write=%0d want 3/7", wait_cyc, wr_cyc); end
        checks++; if (nb != 1 || data_err != 0 || last_end !== 32'h1010) begin
            failures++; $display("FAIL bp_result: got nb=%0d data_err=%0d end=%h want 1/0/1010", nb, data_err, last_end); end
    endtask

    task automatic test_starvation();
        int s; bit ok;
        ckn_level_i = 9'd3;
        push_frame(1, 0, 4, 0, 1);
        start_job(32'h1000, 32'h0, 0, s);
        repeat (10) @(posedge iClk);
        #1;
        checks++; if (nb != 0) begin failures++; $display("FAIL starve_hold: got %0d bursts want 0", nb); end
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL starve_busy: got %b want 1", busy_o); end
        ckn_level_i = 9'd4;
        wait_done(100, ok);
        ckn_level_i = 9'd100;
        checks++; if (!ok) begin failures++; $display("FAIL starve_done: timeout, done not seen"); end
        checks++; if (nb != 1 || log_bc[0] !== 3'd4 || log_addr[0] !== 32'h1000) begin
            failures++; $display("FAIL starve_burst: got nb=%0d %0d@%h want 1 4@1000", nb, log_bc[0], log_addr[0]); end
        checks++; if (n_ckn != 4 || n_done != 1) begin failures++; $display("FAIL starve_fetch: got %0d done=%0d want 4/1", n_ckn, n_done); end
    endtask

    task automatic test_reset_mid();
        int s, n; bit ok;
        push_frame(0, 0, 6, 5, 1);
        start_job(32'h1000, 32'h0, 1, s);
        n = 0;
        while (!oWrite_Master_Write && n < 20) begin @(posedge iClk); #1; n++; end
        checks++; if (!oWrite_Master_Write) begin failures++; $display("FAIL rstmid_start: timeout, oWrite not seen"); end
        @(posedge iClk); #1;
        iRstn = 1'b0;
        #1;
        checks++; if ({oWrite_Master_Write, oAddress_Master_Write, oData_Master_Write, oBurstcount_Master_Write} !== '0) begin
            failures++; $display("FAIL rstmid_bus: got wr=%b addr=%h data=%h bc=%0d want 0", oWrite_Master_Write,
                oAddress_Master_Write, oData_Master_Write, oBurstcount_Master_Write); end
        checks++; if ({busy_o, done_o, ckn_fetch_o, info_req_o, res_fetch_o} !== 5'b0) begin
            failures++; $display("FAIL rstmid_ctrl: got busy=%b done=%b fetch=%b want 0", busy_o, done_o, ckn_fetch_o); end
        do_reset();
        push_frame(1, 0, 2, 0, 1);
        start_job(32'h2000, 32'h0, 1, s);
        wait_done(100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rstmid_done: timeout, done not seen"); end
        checks++; if (nb != 1 || log_addr[0] !== 32'h2000 || log_bc[0] !== 3'd2) begin
            failures++; $display("FAIL rstmid_burst: got nb=%0d %0d@%h want 1 2@2000", nb, log_bc[0], log_addr[0]); end
        checks++; if (last_end !== 32'h2008 || n_done != 1) begin failures++; $display("FAIL rstmid_end: got %h x%0d want 2008 x1", last_end, n_done); end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_tag_fail();
        test_hash();
        test_backpressure();
        test_starvation();
        test_reset_mid();
        repeat (2) @(posedge iClk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
